// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: issue, memory-port and completion signals of the LSU memory stage.
// Latency: none (signal bundle only).
// Backpressure: stage_ready toward issue, mem_req_valid/mem_req_ready toward memory.
// Ports: slave = the memory stage itself; master = its surroundings (issue control,
//        data memory, LDQ/STQ completion consumers).
interface lsu_mem_stage_if #(
  parameter int XLEN          = 32,
  parameter int LDQ_SIZE      = 8,
  parameter int STQ_SIZE      = 8,
  parameter int ROB_TAG_WIDTH = 5
);
  localparam int LDQ_IW = $clog2(LDQ_SIZE);
  localparam int STQ_IW = $clog2(STQ_SIZE);

  logic                     flush;
  logic                     load_executed;
  logic [LDQ_IW-1:0]        ldq_mem_stage_index;
  logic [XLEN-1:0]          load_address;
  logic [2:0]               load_funct3;
  logic [ROB_TAG_WIDTH-1:0] load_rob_tag;
  logic                     store_executed;
  logic [STQ_IW-1:0]        store_executed_index;
  logic [XLEN-1:0]          store_address;
  logic [XLEN-1:0]          store_data;
  logic [2:0]               store_funct3;
  logic                     stage_ready;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_we;
  logic [XLEN-1:0]          mem_addr;
  logic [XLEN-1:0]          mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_resp_valid;
  logic [XLEN-1:0]          mem_resp_rdata;
  logic                     load_result_valid;
  logic [LDQ_IW-1:0]        load_result_index;
  logic [ROB_TAG_WIDTH-1:0] load_result_rob_tag;
  logic [XLEN-1:0]          load_result_data;
  logic                     store_done_valid;
  logic [STQ_IW-1:0]        store_done_index;

  modport slave (
    input  flush, load_executed, ldq_mem_stage_index, load_address, load_funct3,
           load_rob_tag, store_executed, store_executed_index, store_address,
           store_data, store_funct3, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output stage_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
           load_result_valid, load_result_index, load_result_rob_tag,
           load_result_data, store_done_valid, store_done_index
  );

  modport master (
    output flush, load_executed, ldq_mem_stage_index, load_address, load_funct3,
           load_rob_tag, store_executed, store_executed_index, store_address,
           store_data, store_funct3, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  stage_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
           load_result_valid, load_result_index, load_result_rob_tag,
           load_result_data, store_done_valid, store_done_index
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: LSU memory-access stage; one load or committed store at a time to a
//   single-outstanding data-memory port, with load alignment/extension and completions.
// Latency: accept edge -> REQ (>=1 cycle) -> WAIT; result is combinational with the response.
// Backpressure: stage_ready only in IDLE; request fields held until mem_req_ready.
// Ports: clk, reset_n (async active-low), bus (lsu_mem_stage_if.slave).
module lsu_mem_stage #(
  parameter int XLEN          = 32,
  parameter int LDQ_SIZE      = 8,
  parameter int STQ_SIZE      = 8,
  parameter int ROB_TAG_WIDTH = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  lsu_mem_stage_if.slave bus
);
  localparam int LDQ_IW = $clog2(LDQ_SIZE);
  localparam int STQ_IW = $clog2(STQ_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic                     is_load_q;
  logic [LDQ_IW-1:0]        ldq_idx_q;
  logic [STQ_IW-1:0]        stq_idx_q;
  logic [ROB_TAG_WIDTH-1:0] tag_q;
  logic [2:0]               funct3_q;
  logic [XLEN-1:0]          addr_q;   // addr_q[1:0] is the byte offset within the word
  logic [XLEN-1:0]          data_q;
  logic                     killed_q;

  logic                     load_acc;
  logic                     store_acc;
  logic [XLEN-1:0]          ld_shift;

  // A load seen together with flush is on the wrong path and is dropped. A store is
  // taken whenever no load is taken, so a dropped load does not waste the slot.
  assign load_acc  = (state_q == IDLE) && bus.load_executed && !bus.flush;
  assign store_acc = (state_q == IDLE) && bus.store_executed && !load_acc;

  assign ld_shift  = bus.mem_resp_rdata >> {addr_q[1:0], 3'b000};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_acc || store_acc) state_d = REQ;
      REQ:     if (bus.mem_req_ready)     state_d = WAIT;
      WAIT:    if (bus.mem_resp_valid)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation capture and kill tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_load_q <= 1'b0;
      ldq_idx_q <= '0;
      stq_idx_q <= '0;
      tag_q     <= '0;
      funct3_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      killed_q  <= 1'b0;
    end else if (load_acc) begin
      is_load_q <= 1'b1;
      ldq_idx_q <= bus.ldq_mem_stage_index;
      tag_q     <= bus.load_rob_tag;
      funct3_q  <= bus.load_funct3;
      addr_q    <= bus.load_address;
      data_q    <= '0;
      killed_q  <= 1'b0;
    end else if (store_acc) begin
      is_load_q <= 1'b0;
      stq_idx_q <= bus.store_executed_index;
      funct3_q  <= bus.store_funct3;
      addr_q    <= bus.store_address;
      data_q    <= bus.store_data;
      killed_q  <= 1'b0;
    end else if (bus.flush && is_load_q && (state_q == REQ || state_q == WAIT)) begin
      // The memory access still runs to completion; only the writeback is dropped.
      killed_q  <= 1'b1;
    end
  end

  // Outputs
  always_comb begin
    bus.stage_ready         = (state_q == IDLE);
    bus.mem_req_valid       = 1'b0;
    bus.mem_we              = 1'b0;
    bus.mem_addr            = '0;
    bus.mem_wdata           = '0;
    bus.mem_wstrb           = 4'b0000;
    bus.load_result_valid   = 1'b0;
    bus.load_result_index   = '0;
    bus.load_result_rob_tag = '0;
    bus.load_result_data    = '0;
    bus.store_done_valid    = 1'b0;
    bus.store_done_index    = '0;

    if (state_q == REQ) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_addr      = {addr_q[XLEN-1:2], 2'b00};
      if (!is_load_q) begin
        bus.mem_we = 1'b1;
        case (funct3_q[1:0])
          2'b00: begin
            bus.mem_wstrb = 4'b0001 << addr_q[1:0];
            bus.mem_wdata = {4{data_q[7:0]}};
          end
          2'b01: begin
            bus.mem_wstrb = 4'b0011 << addr_q[1:0];
            bus.mem_wdata = {2{data_q[15:0]}};
          end
          default: begin
            bus.mem_wstrb = 4'b1111;
            bus.mem_wdata = data_q;
          end
        endcase
      end
    end

    if (state_q == WAIT && bus.mem_resp_valid) begin
      if (is_load_q) begin
        // A flush arriving with the response itself also drops the result.
        if (!killed_q && !bus.flush) begin
          bus.load_result_valid   = 1'b1;
          bus.load_result_index   = ldq_idx_q;
          bus.load_result_rob_tag = tag_q;
          case (funct3_q)
            3'b000:  bus.load_result_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  bus.load_result_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  bus.load_result_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  bus.load_result_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: bus.load_result_data = ld_shift;
          endcase
        end
      end else begin
        bus.store_done_valid = 1'b1;
        bus.store_done_index = stq_idx_q;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage with a load/store completion scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled a unit later / at negedge.
// Backpressure: memory ready/response driven step by step from the initial block.
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lsu_mem_stage_if #(.XLEN(32), .LDQ_SIZE(8), .STQ_SIZE(8), .ROB_TAG_WIDTH(5)) bus ();

  lsu_mem_stage #(.XLEN(32), .LDQ_SIZE(8), .STQ_SIZE(8), .ROB_TAG_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  tag;
    logic [31:0] data;
  } ld_exp_t;

  ld_exp_t    ld_q[$];
  logic [2:0] st_q[$];
  ld_exp_t    mon_e;
  logic [2:0] mon_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Completion monitor: every writeback / store-done must match the scoreboard head.
  always @(negedge clk) begin
    if (bus.load_result_valid === 1'b1) begin
      if (ld_q.size() == 0) begin
        chk("ld_unexpected", {31'b0, bus.load_result_valid}, 32'd0);
      end else begin
        mon_e = ld_q.pop_front();
        chk("ld_idx",  {29'b0, bus.load_result_index},   {29'b0, mon_e.idx});
        chk("ld_tag",  {27'b0, bus.load_result_rob_tag}, {27'b0, mon_e.tag});
        chk("ld_data", bus.load_result_data, mon_e.data);
      end
    end
    if (bus.store_done_valid === 1'b1) begin
      if (st_q.size() == 0) begin
        chk("st_unexpected", {31'b0, bus.store_done_valid}, 32'd0);
      end else begin
        mon_s = st_q.pop_front();
        chk("st_idx", {29'b0, bus.store_done_index}, {29'b0, mon_s});
      end
    end
  end

  task automatic do_load(input logic [2:0] idx, input logic [4:0] tag, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    ld_exp_t e;
    bus.load_executed = 1'b1;
    bus.ldq_mem_stage_index = idx;
    bus.load_rob_tag = tag;
    bus.load_address = addr;
    bus.load_funct3 = f3;
    settle();
    chk("ld_ready_idle", {31'b0, bus.stage_ready}, 32'd1);
    cyc();
    bus.load_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("ld_req_vld",  {31'b0, bus.mem_req_valid}, 32'd1);
    chk("ld_req_addr", bus.mem_addr, exp_addr);
    chk("ld_req_we",   {31'b0, bus.mem_we}, 32'd0);
    chk("ld_req_strb", {28'b0, bus.mem_wstrb}, 32'd0);
    cyc();
    bus.mem_req_ready = 1'b0;
    e.idx = idx;
    e.tag = tag;
    e.data = exp_data;
    ld_q.push_back(e);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    settle();
    chk("ld_res_vld", {31'b0, bus.load_result_valid}, 32'd1);
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ld_ready_after", {31'b0, bus.stage_ready}, 32'd1);
  endtask

  task automatic do_store(input logic [2:0] idx, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] f3, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    bus.store_executed = 1'b1;
    bus.store_executed_index = idx;
    bus.store_address = addr;
    bus.store_data = data;
    bus.store_funct3 = f3;
    cyc();
    bus.store_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("st_req_vld",   {31'b0, bus.mem_req_valid}, 32'd1);
    chk("st_req_we",    {31'b0, bus.mem_we}, 32'd1);
    chk("st_req_addr",  bus.mem_addr, exp_addr);
    chk("st_req_strb",  {28'b0, bus.mem_wstrb}, {28'b0, exp_strb});
    chk("st_req_wdata", bus.mem_wdata, exp_wdata);
    cyc();
    bus.mem_req_ready = 1'b0;
    st_q.push_back(idx);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0;
    settle();
    chk("st_done_vld", {31'b0, bus.store_done_valid}, 32'd1);
    cyc();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.flush = 1'b0;
    bus.load_executed = 1'b0;
    bus.ldq_mem_stage_index = '0;
    bus.load_address = '0;
    bus.load_funct3 = '0;
    bus.load_rob_tag = '0;
    bus.store_executed = 1'b0;
    bus.store_executed_index = '0;
    bus.store_address = '0;
    bus.store_data = '0;
    bus.store_funct3 = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    // Reset state
    #2;
    chk("rst_req_vld", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("rst_ld_vld",  {31'b0, bus.load_result_valid}, 32'd0);
    chk("rst_st_vld",  {31'b0, bus.store_done_valid}, 32'd0);
    chk("rst_addr",    bus.mem_addr, 32'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    settle();
    chk("rst_ready", {31'b0, bus.stage_ready}, 32'd1);
    cyc();

    // LB signed, offset 3
    do_load(3'd2, 5'd7, 32'h0000_0103, 3'b000, 32'h80AA_BBCC, 32'h0000_0100, 32'hFFFF_FF80);
    // SH, offset 2
    do_store(3'd5, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    // Extra widths / lanes
    do_load(3'd0, 5'd1, 32'h0000_0802, 3'b001, 32'h8001_1234, 32'h0000_0800, 32'hFFFF_8001);
    do_load(3'd4, 5'd2, 32'h0000_0806, 3'b101, 32'h8001_1234, 32'h0000_0804, 32'h0000_8001);
    do_load(3'd6, 5'd3, 32'h0000_0809, 3'b100, 32'h0000_9A00, 32'h0000_0808, 32'h0000_009A);
    do_store(3'd1, 32'h0000_0903, 32'h0000_00A5, 3'b000, 32'h0000_0900, 4'b1000, 32'hA5A5_A5A5);

    // Simultaneous load + store, memory stalls 3 cycles
    bus.load_executed = 1'b1;
    bus.ldq_mem_stage_index = 3'd3;
    bus.load_rob_tag = 5'd9;
    bus.load_address = 32'h0000_0300;
    bus.load_funct3 = 3'b010;
    bus.store_executed = 1'b1;
    bus.store_executed_index = 3'd6;
    bus.store_address = 32'h0000_0400;
    bus.store_data = 32'h0000_0055;
    bus.store_funct3 = 3'b010;
    cyc();
    bus.load_executed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready = (i == 3);
      settle();
      chk("bp_req_vld",  {31'b0, bus.mem_req_valid}, 32'd1);
      chk("bp_req_addr", bus.mem_addr, 32'h0000_0300);
      chk("bp_req_we",   {31'b0, bus.mem_we}, 32'd0);
      chk("bp_ready",    {31'b0, bus.stage_ready}, 32'd0);
      cyc();
    end
    bus.mem_req_ready = 1'b0;
    settle();
    chk("bp_wait_ready", {31'b0, bus.stage_ready}, 32'd0);
    ld_q.push_back('{idx: 3'd3, tag: 5'd9, data: 32'hCAFE_F00D});
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFE_F00D;
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("bp_idle_ready", {31'b0, bus.stage_ready}, 32'd1);
    cyc();
    bus.store_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("bp_st_we",    {31'b0, bus.mem_we}, 32'd1);
    chk("bp_st_addr",  bus.mem_addr, 32'h0000_0400);
    chk("bp_st_strb",  {28'b0, bus.mem_wstrb}, 32'h0000_000F);
    chk("bp_st_wdata", bus.mem_wdata, 32'h0000_0055);
    cyc();
    bus.mem_req_ready = 1'b0;
    st_q.push_back(3'd6);
    bus.mem_resp_valid = 1'b1;
    cyc();
    bus.mem_resp_valid = 1'b0;

    // Load presented with flush is not accepted
    bus.load_executed = 1'b1;
    bus.flush = 1'b1;
    bus.load_address = 32'h0000_0A00;
    cyc();
    bus.load_executed = 1'b0;
    bus.flush = 1'b0;
    settle();
    chk("fl_acc_ready",   {31'b0, bus.stage_ready}, 32'd1);
    chk("fl_acc_req_vld", {31'b0, bus.mem_req_valid}, 32'd0);

    // Flush during WAIT of LW
    bus.load_executed = 1'b1;
    bus.ldq_mem_stage_index = 3'd1;
    bus.load_rob_tag = 5'd4;
    bus.load_address = 32'h0000_0500;
    bus.load_funct3 = 3'b010;
    cyc();
    bus.load_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hDEAD_BEEF;
    settle();
    chk("fl_wait_no_res", {31'b0, bus.load_result_valid}, 32'd0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("fl_wait_ready", {31'b0, bus.stage_ready}, 32'd1);

    // Flush in the response cycle itself
    bus.load_executed = 1'b1;
    bus.load_address = 32'h0000_0504;
    cyc();
    bus.load_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.flush = 1'b1;
    bus.mem_resp_valid = 1'b1;
    settle();
    chk("fl_resp_no_res", {31'b0, bus.load_result_valid}, 32'd0);
    cyc();
    bus.flush = 1'b0;
    bus.mem_resp_valid = 1'b0;

    // Store immune to flush while in REQ
    bus.store_executed = 1'b1;
    bus.store_executed_index = 3'd3;
    bus.store_address = 32'h0000_0600;
    bus.store_data = 32'h1122_3344;
    bus.store_funct3 = 3'b010;
    cyc();
    bus.store_executed = 1'b0;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("st_fl_req_vld", {31'b0, bus.mem_req_valid}, 32'd1);
    chk("st_fl_wdata",   bus.mem_wdata, 32'h1122_3344);
    cyc();
    bus.mem_req_ready = 1'b0;
    st_q.push_back(3'd3);
    bus.mem_resp_valid = 1'b1;
    settle();
    chk("st_fl_done", {31'b0, bus.store_done_valid}, 32'd1);
    cyc();
    bus.mem_resp_valid = 1'b0;

    // Reset during WAIT of LHU
    bus.load_executed = 1'b1;
    bus.ldq_mem_stage_index = 3'd7;
    bus.load_rob_tag = 5'd31;
    bus.load_address = 32'h0000_0702;
    bus.load_funct3 = 3'b101;
    cyc();
    bus.load_executed = 1'b0;
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    reset_n = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hFFFF_0000;
    settle();
    chk("mid_rst_req_vld", {31'b0, bus.mem_req_valid}, 32'd0);
    chk("mid_rst_ld_vld",  {31'b0, bus.load_result_valid}, 32'd0);
    chk("mid_rst_ld_data", bus.load_result_data, 32'd0);
    chk("mid_rst_ld_idx",  {29'b0, bus.load_result_index}, 32'd0);
    chk("mid_rst_ld_tag",  {27'b0, bus.load_result_rob_tag}, 32'd0);
    chk("mid_rst_st_vld",  {31'b0, bus.store_done_valid}, 32'd0);
    chk("mid_rst_addr",    bus.mem_addr, 32'd0);
    chk("mid_rst_strb",    {28'b0, bus.mem_wstrb}, 32'd0);
    cyc();
    reset_n = 1'b1;
    settle();
    chk("post_rst_ready",  {31'b0, bus.stage_ready}, 32'd1);
    chk("post_rst_no_res", {31'b0, bus.load_result_valid}, 32'd0);
    cyc();
    bus.mem_resp_valid = 1'b0;

    // A normal load still works after the reset
    do_load(3'd5, 5'd12, 32'h0000_0B00, 3'b010, 32'h0BAD_F00D, 32'h0000_0B00, 32'h0BAD_F00D);

    cyc();
    chk("ld_q_empty", ld_q.size(), 32'd0);
    chk("st_q_empty", st_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
